// File: rtl/seq_adder_pkg.sv
// Shared definitions for the sequential chunked adder: FSM encoding and index sizing.
package seq_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // A single-chunk configuration still needs a 1-bit index register.
    function automatic int idx_width(input int nchunk);
        return (nchunk > 1) ? $clog2(nchunk) : 1;
    endfunction

endpackage

// File: rtl/chunk_ripple_adder.sv
// Combinational CHUNK-bit ripple of full-adder cells; also exposes the carry into the MSB
// so the caller can derive signed overflow.
module chunk_ripple_adder #(
    parameter int CHUNK = 8
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    logic [CHUNK:0] c;

    assign c[0] = cin;

    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
        assign s[gi]   = a[gi] ^ b[gi] ^ c[gi];
        assign c[gi+1] = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
    end

    assign cout  = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/seq_chunk_adder.sv
// Multi-cycle add/subtract, CHUNK bits per clock LSB-first, valid/ready on both sides.
// Optional signed-overflow output is enabled by defining SEQ_CHUNK_ADDER_OVF_EN.
module seq_chunk_adder
    import seq_adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int             NCHUNK   = WIDTH / CHUNK;
    localparam int             IW       = idx_width(NCHUNK);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NCHUNK - 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]  a_shift, b_shift;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CHUNK-1:0]  add_s;
    logic              add_cout, add_cmsb;

    // Operands shift right each RUN cycle so the active chunk is always at the bottom.
    if (NCHUNK > 1) begin : g_shift
        assign a_shift = {{CHUNK{1'b0}}, a_q[WIDTH-1:CHUNK]};
        assign b_shift = {{CHUNK{1'b0}}, b_q[WIDTH-1:CHUNK]};
    end else begin : g_noshift
        assign a_shift = a_q;
        assign b_shift = b_q;
    end

    chunk_ripple_adder #(.CHUNK(CHUNK)) u_chunk_add (
        .a     (a_q[CHUNK-1:0]),
        .b     (b_q[CHUNK-1:0]),
        .cin   (carry_q),
        .s     (add_s),
        .cout  (add_cout),
        .c_msb (add_cmsb)
    );

    for (genvar gi = 0; gi < NCHUNK; gi++) begin : g_sum
        assign sum_d[gi*CHUNK +: CHUNK] = (state_q == RUN && idx_q == IW'(gi))
                                        ? add_s : sum_q[gi*CHUNK +: CHUNK];
    end

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic ovf_q, ovf_d;
    assign ovf = ovf_q;
`else
    logic cmsb_unused;
    assign cmsb_unused = add_cmsb;
`endif

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        carry_d   = carry_q;
        cout_d    = cout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        ovf_d     = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = a;
                    // Subtraction is a + ~b + 1, so cin is replaced by the forced 1.
                    b_d     = sub ? ~b : b;
                    carry_d = sub ? 1'b1 : cin;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_shift;
                b_d     = b_shift;
                carry_d = add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = add_cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
                    ovf_d   = add_cmsb ^ add_cout;
`endif
                    state_d = DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_seq_chunk_adder.sv
// Directed bench for seq_chunk_adder (WIDTH=16, CHUNK=4); with SEQ_CHUNK_ADDER_OVF_EN it also
// checks ovf and a second WIDTH=8, CHUNK=8 instance.
module tb_seq_chunk_adder;

    localparam int W = 16;
    localparam int C = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  a = '0;
    logic [W-1:0]  b = '0;
    logic          cin = 1'b0;
    logic          sub = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  sum;
    logic          cout;
`ifdef SEQ_CHUNK_ADDER_OVF_EN
    logic          ovf;
    logic          in_valid2 = 1'b0;
    logic          in_ready2;
    logic [7:0]    a2 = '0;
    logic [7:0]    b2 = '0;
    logic          out_valid2;
    logic          out_ready2 = 1'b0;
    logic [7:0]    sum2;
    logic          cout2;
    logic          ovf2;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_chunk_adder #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        .ovf       (ovf),
`endif
        .cout      (cout)
    );

`ifdef SEQ_CHUNK_ADDER_OVF_EN
    seq_chunk_adder #(.WIDTH(8), .CHUNK(8)) dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid2),
        .in_ready  (in_ready2),
        .a         (a2),
        .b         (b2),
        .cin       (1'b0),
        .sub       (1'b0),
        .out_valid (out_valid2),
        .out_ready (out_ready2),
        .sum       (sum2),
        .ovf       (ovf2),
        .cout      (cout2)
    );
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            step();
            guard++;
        end
        check("accept_ready", 32'(in_ready), 32'd1);
        a        = ta;
        b        = tb_v;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!out_valid && lat < 50) begin
            step();
            lat++;
        end
        check("wait_valid", 32'(out_valid), 32'd1);
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        check("handoff_in_ready", 32'(in_ready), 32'd1);
    endtask

    task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                          input logic tcin, input logic tsub, input logic [W-1:0] esum,
                          input logic ecout, input logic eovf);
        int lat;
        accept(ta, tb_v, tcin, tsub);
        wait_valid(lat);
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_sum"}, 32'(sum), 32'(esum));
        check({tag, "_cout"}, 32'(cout), 32'(ecout));
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        check({tag, "_ovf"}, 32'(ovf), 32'(eovf));
`endif
        $display("op %s: a=%h b=%h cin=%b sub=%b -> sum=%h cout=%b lat=%0d (exp sum=%h cout=%b ovf=%b)",
                 tag, ta, tb_v, tcin, tsub, sum, cout, lat, esum, ecout, eovf);
        handoff();
    endtask

    initial begin
        int lat;
        int stray;

        // Reset with in_valid asserted: it must be ignored.
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 16'hDEAD;
        b        = 16'hBEEF;
        step();
        step();
        step();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
`ifdef SEQ_CHUNK_ADDER_OVF_EN
        check("rst_ovf", 32'(ovf), 32'd0);
`endif
        in_valid = 1'b0;
        rst      = 1'b0;
        step();
        check("idle_out_valid", 32'(out_valid), 32'd0);

        run_op("add_00ff_0001", 16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_op("add_ffff_0001", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_op("add_1234_4321_c", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);
        run_op("sub_7_5", 16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        run_op("sub_5_7", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_op("add_7fff_0001", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_op("sub_8000_0001", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Backpressure: DONE held with new operands offered; they must be dropped.
        accept(16'h1111, 16'h2222, 1'b0, 1'b0);
        wait_valid(lat);
        check("bp_latency", 32'(lat), 32'd4);
        for (int i = 0; i < 6; i++) begin
            a        = 16'hAAAA;
            b        = 16'h5555;
            in_valid = 1'b1;
            step();
            check("bp_sum", 32'(sum), 32'h3333);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b0;
        $display("op backpressure: a=1111 b=2222 held 6 cycles -> sum=%h cout=%b", sum, cout);
        handoff();
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) stray++;
        end
        check("bp_dropped_ops", 32'(stray), 32'd0);
        run_op("add_after_bp", 16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0);

        // Reset asserted during the second RUN cycle discards the operation.
        accept(16'h1111, 16'h1111, 1'b0, 1'b0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_sum", 32'(sum), 32'd0);
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (out_valid) stray++;
        end
        check("midrst_no_valid", 32'(stray), 32'd0);
        $display("op reset_mid_run: operation discarded");
        run_op("add_0f0f_00f1", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);

`ifdef SEQ_CHUNK_ADDER_OVF_EN
        // Single-chunk instance: RUN lasts exactly one cycle.
        check("n1_in_ready", 32'(in_ready2), 32'd1);
        a2        = 8'h7F;
        b2        = 8'h01;
        in_valid2 = 1'b1;
        step();
        in_valid2 = 1'b0;
        check("n1_run_out_valid", 32'(out_valid2), 32'd0);
        step();
        check("n1_out_valid", 32'(out_valid2), 32'd1);
        check("n1_sum", 32'(sum2), 32'h80);
        check("n1_cout", 32'(cout2), 32'd0);
        check("n1_ovf", 32'(ovf2), 32'd1);
        $display("op n1_add_7f_01: sum=%h cout=%b ovf=%b", sum2, cout2, ovf2);
        out_ready2 = 1'b1;
        step();
        out_ready2 = 1'b0;
        check("n1_handoff", 32'(out_valid2), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
